tpu_out_drain: RTL



---
 rtl/tpu_out_drain_if.sv | 54 +++++
 rtl/tpu_out_drain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_out_drain_if.sv
// ---------------------------------------------------------------------------
// tpu_out_drain_if
//
// Bundles the row-input side and the word-output side of the TPU output
// drain into one interface. The drain block connects through the 'slave'
// modport. The block feeding rows and consuming words connects through the
// 'master' modport.
//
// Signals:
//   in_valid   row strobe (top out_valid)
//   in_data    256-bit result row (top gbuff_out)
//   out_valid  word available on out_data
//   out_ready  downstream accepts the current word
//   out_data   current 32-bit word
//   out_last   final word of a result matrix
//   overflow   sticky flag: at least one row was dropped
//   busy       FIFO non-empty or a row is being serialized
//   out_parity XOR-reduce of out_data (only with TPU_OUT_DRAIN_PARITY_EN)
//
// Optional feature macro: TPU_OUT_DRAIN_PARITY_EN
// ---------------------------------------------------------------------------
interface tpu_out_drain_if;

  logic         in_valid;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         overflow;
  logic         busy;
`ifdef TPU_OUT_DRAIN_PARITY_EN
  logic         out_parity;
`endif

  // Drain side: takes rows in, pushes words out.
  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef TPU_OUT_DRAIN_PARITY_EN
    output out_parity,
`endif
    output out_valid, out_data, out_last, overflow, busy
  );

  // Producer/consumer side: drives rows and ready, observes the stream.
  modport master (
    output in_valid, in_data, out_ready,
`ifdef TPU_OUT_DRAIN_PARITY_EN
    input  out_parity,
`endif
    input  out_valid, out_data, out_last, overflow, busy
  );

endinterface

// File: rtl/tpu_out_drain.sv
// ---------------------------------------------------------------------------
// tpu_out_drain
//
// Downstream stage of the TPU matmul top. Result rows arrive as 256-bit
// bursts that cannot be back-pressured. Each row is buffered in a FIFO and
// then serialized as eight 32-bit words on a valid/ready stream. Word 0 is
// row bits [31:0]. If a row arrives while the FIFO is full and no pop
// happens in the same cycle, the row is dropped and a sticky overflow flag
// is raised.
//
// Parameters:
//   ROWS        FIFO depth in 256-bit rows (power of 2, >= 2)
//   BURST_ROWS  rows per result matrix; out_last marks its final word
//
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    tpu_out_drain_if.slave (row input, word stream, status)
//
// Optional feature macro: TPU_OUT_DRAIN_PARITY_EN
//   When defined, bus.out_parity carries the XOR-reduce of out_data. It is
//   registered together with out_data, so it follows the same stability rule.
// ---------------------------------------------------------------------------
module tpu_out_drain #(
  parameter int ROWS       = 32,
  parameter int BURST_ROWS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  tpu_out_drain_if.slave bus
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (BURST_ROWS > 1) ? $clog2(BURST_ROWS) : 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  // FIFO storage and bookkeeping
  logic [255:0]  mem_q [ROWS];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  // Serializer state and registered outputs
  state_e        state_q;
  logic [255:0]  row_q;
  logic [2:0]    idx_q;
  logic [RW-1:0] rowCnt_q;
  logic          outValid_q;
  logic [31:0]   outData_q;
  logic          outLast_q;
`ifdef TPU_OUT_DRAIN_PARITY_EN
  logic          outParity_q;
`endif

  logic          handshake;
  logic          lastWord;
  logic          lastRowOfBurst;
  logic          fifoEmpty;
  logic          fifoFull;
  logic          pop;
  logic          push;
  logic [255:0]  popRow;
  logic [2:0]    nextIdx;
  logic [31:0]   nextWord;

  assign handshake      = outValid_q & bus.out_ready;
  assign lastWord       = (idx_q == 3'd7);
  assign lastRowOfBurst = (rowCnt_q == RW'(BURST_ROWS - 1));
  assign fifoEmpty      = (count_q == '0);
  assign fifoFull       = (count_q == CW'(ROWS));

  // A pop refills the row register: either from idle, or back-to-back when
  // the last word of the current row is accepted, so the stream has no gap.
  assign pop = !fifoEmpty &&
               ((state_q == S_IDLE) ||
                ((state_q == S_SEND) && handshake && lastWord));

  // A full FIFO still accepts a row if a slot is vacated on the same edge.
  assign push = bus.in_valid && (!fifoFull || pop);

  assign popRow   = mem_q[rdPtr_q];
  assign nextIdx  = idx_q + 3'd1;
  assign nextWord = row_q[{nextIdx, 5'd0} +: 32];

  // Row storage has no reset so it can map onto plain RAM. Stale contents
  // are never visible because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.in_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because ROWS is a power of two. A simultaneous push and pop
  // leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.in_valid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Serializer FSM. out_data/out_last/out_valid are registered here and only
  // change on a handshake or a refill from idle, which keeps them stable
  // while the consumer stalls. out_last is precomputed for the word being
  // loaded. The row counter only moves when the eighth word is accepted,
  // so dropped rows never count toward a matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      rowCnt_q    <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
`ifdef TPU_OUT_DRAIN_PARITY_EN
      outParity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q     <= S_SEND;
            row_q       <= popRow;
            idx_q       <= 3'd0;
            outValid_q  <= 1'b1;
            outData_q   <= popRow[31:0];
            outLast_q   <= 1'b0;
`ifdef TPU_OUT_DRAIN_PARITY_EN
            outParity_q <= ^popRow[31:0];
`endif
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (!lastWord) begin
              idx_q       <= nextIdx;
              outData_q   <= nextWord;
              outLast_q   <= (nextIdx == 3'd7) && lastRowOfBurst;
`ifdef TPU_OUT_DRAIN_PARITY_EN
              outParity_q <= ^nextWord;
`endif
            end else begin
              rowCnt_q <= lastRowOfBurst ? '0 : rowCnt_q + RW'(1);
              if (pop) begin
                row_q       <= popRow;
                idx_q       <= 3'd0;
                outData_q   <= popRow[31:0];
                outLast_q   <= 1'b0;
`ifdef TPU_OUT_DRAIN_PARITY_EN
                outParity_q <= ^popRow[31:0];
`endif
              end else begin
                state_q     <= S_IDLE;
                idx_q       <= 3'd0;
                outValid_q  <= 1'b0;
                outData_q   <= '0;
                outLast_q   <= 1'b0;
`ifdef TPU_OUT_DRAIN_PARITY_EN
                outParity_q <= 1'b0;
`endif
              end
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = !fifoEmpty || (state_q == S_SEND);
`ifdef TPU_OUT_DRAIN_PARITY_EN
  assign bus.out_parity = outParity_q;
`endif

endmodule
